// File: rtl/notif_arbiter_if.sv
// Notification arbiter bus: per-source strobes and messages in, one merged
// notification plus per-source sticky overflow flags out.
// master = notification producers/consumer side, slave = the arbiter.
interface notif_arbiter_if #(
  parameter int p_num_srcs = 4,
  parameter int p_msg_bits = 32
);
  localparam int c_src_bits = $clog2(p_num_srcs);

  logic [p_num_srcs-1:0]                 src_val;
  logic [p_num_srcs-1:0][p_msg_bits-1:0] src_msg;
  logic                                  out_val;
  logic [p_msg_bits-1:0]                 out_msg;
  logic [c_src_bits-1:0]                 out_src;
  logic [p_num_srcs-1:0]                 overflow;

  modport master (
    output src_val, src_msg,
    input  out_val, out_msg, out_src, overflow
  );

  modport slave (
    input  src_val, src_msg,
    output out_val, out_msg, out_src, overflow
  );
endinterface

// File: rtl/notif_arbiter.sv
// Round-robin notification merger with a small pending FIFO per source.
// A source with queued entries always competes with its FIFO head, so a new
// arrival can only bypass the FIFO when that FIFO is empty; this keeps
// per-source ordering. Arrivals into a full, non-granted FIFO are dropped
// and flagged in a sticky overflow bit.
// Optional build macro NOTIF_ARBITER_BYPASS_EN: outputs driven combinationally
// from the current grant (zero latency, msg/src forced to 0 when idle).
// Without it, outputs are registered one cycle after the grant and msg/src
// hold their last value while idle.
module notif_arbiter #(
  parameter int p_num_srcs = 4,
  parameter int p_msg_bits = 32,
  parameter int p_depth    = 2
) (
  input  logic             clk,
  input  logic             rst,
  notif_arbiter_if.slave   bus
);

  localparam int c_src_bits = $clog2(p_num_srcs);
  localparam int c_ptr_bits = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int c_cnt_bits = $clog2(p_depth + 1);

  typedef logic [p_msg_bits-1:0] msg_t;
  typedef logic [c_ptr_bits-1:0] ptr_t;
  typedef logic [c_cnt_bits-1:0] cnt_t;

  msg_t                  mem_q    [p_num_srcs][p_depth];
  ptr_t                  rd_ptr_q [p_num_srcs];
  ptr_t                  rd_ptr_d [p_num_srcs];
  ptr_t                  wr_ptr_q [p_num_srcs];
  ptr_t                  wr_ptr_d [p_num_srcs];
  cnt_t                  cnt_q    [p_num_srcs];
  cnt_t                  cnt_d    [p_num_srcs];
  logic [c_src_bits-1:0] rr_ptr_q, rr_ptr_d;
  logic [p_num_srcs-1:0] ovf_q, ovf_d;

  logic [p_num_srcs-1:0] empty, full, cand;
  msg_t                  cand_msg [p_num_srcs];
  logic [p_num_srcs-1:0] deq, enq, drop;

  logic                  gnt_val;
  logic [c_src_bits-1:0] gnt_src;
  msg_t                  gnt_msg;
  logic [p_num_srcs-1:0] gnt_vec;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (int'(p) == p_depth - 1) return '0;
    else return p + 1'b1;
  endfunction

  // Per-source candidate: FIFO head if anything is queued, else a live arrival.
  always_comb begin
    for (int i = 0; i < p_num_srcs; i++) begin
      empty[i]    = (cnt_q[i] == '0);
      full[i]     = (cnt_q[i] == c_cnt_bits'(p_depth));
      cand[i]     = rst & (!empty[i] | bus.src_val[i]);
      cand_msg[i] = empty[i] ? bus.src_msg[i] : mem_q[i][rd_ptr_q[i]];
    end
  end

  // Round-robin search starting at rr_ptr_q, first candidate wins.
  always_comb begin
    logic [c_src_bits-1:0] idx;
    idx     = '0;
    gnt_val = 1'b0;
    gnt_src = '0;
    gnt_msg = '0;
    gnt_vec = '0;
    for (int k = 0; k < p_num_srcs; k++) begin
      idx = c_src_bits'((int'(rr_ptr_q) + k) % p_num_srcs);
      if (!gnt_val && cand[idx]) begin
        gnt_val = 1'b1;
        gnt_src = idx;
        gnt_msg = cand_msg[idx];
      end
    end
    if (gnt_val) gnt_vec[gnt_src] = 1'b1;
  end

  // Queue actions: a granted arrival into an empty FIFO goes straight out;
  // a full FIFO still accepts an arrival when its head leaves this cycle.
  always_comb begin
    for (int i = 0; i < p_num_srcs; i++) begin
      logic arr;
      arr     = rst & bus.src_val[i] & !(gnt_vec[i] & empty[i]);
      deq[i]  = gnt_vec[i] & !empty[i];
      enq[i]  = arr & (!full[i] | gnt_vec[i]);
      drop[i] = arr & full[i] & !gnt_vec[i];
    end
  end

  // Next-state for FIFO pointers/counts, overflow flags and priority pointer.
  always_comb begin
    for (int i = 0; i < p_num_srcs; i++) begin
      rd_ptr_d[i] = rd_ptr_q[i];
      wr_ptr_d[i] = wr_ptr_q[i];
      cnt_d[i]    = cnt_q[i];
      if (deq[i]) rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      if (enq[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
      if (enq[i] && !deq[i])      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (deq[i] && !enq[i]) cnt_d[i] = cnt_q[i] - 1'b1;
    end
    ovf_d    = ovf_q | drop;
    rr_ptr_d = rr_ptr_q;
    if (gnt_val)
      rr_ptr_d = (gnt_src == c_src_bits'(p_num_srcs - 1)) ? '0 : gnt_src + 1'b1;
  end

  // Control state with synchronous active-low reset; reset drops all pending.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < p_num_srcs; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q <= '0;
      ovf_q    <= '0;
    end else begin
      for (int i = 0; i < p_num_srcs; i++) begin
        rd_ptr_q[i] <= rd_ptr_d[i];
        wr_ptr_q[i] <= wr_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by cnt_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < p_num_srcs; i++) begin
      if (enq[i]) mem_q[i][wr_ptr_q[i]] <= bus.src_msg[i];
    end
  end

`ifdef NOTIF_ARBITER_BYPASS_EN
  assign bus.out_val = gnt_val;
  assign bus.out_msg = gnt_val ? gnt_msg : '0;
  assign bus.out_src = gnt_val ? gnt_src : '0;
`else
  logic                  out_val_q;
  msg_t                  out_msg_q;
  logic [c_src_bits-1:0] out_src_q;

  // Register the grant; message and source hold while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= '0;
    end else begin
      out_val_q <= gnt_val;
      if (gnt_val) begin
        out_msg_q <= gnt_msg;
        out_src_q <= gnt_src;
      end
    end
  end

  assign bus.out_val = out_val_q;
  assign bus.out_msg = out_msg_q;
  assign bus.out_src = out_src_q;
`endif

  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_notif_arbiter.sv
// Bench for notif_arbiter: a queue-based reference model feeds a scoreboard
// of expected grants; a table of hand-derived cycle vectors plus short
// sequences cover FIFO fill, drop, full-and-granted, and mid-burst reset.
`timescale 1ns/1ps
module tb_notif_arbiter;
  localparam int NS    = 4;
  localparam int MB    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  notif_arbiter_if #(.p_num_srcs(NS), .p_msg_bits(MB)) bus();

  notif_arbiter #(.p_num_srcs(NS), .p_msg_bits(MB), .p_depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [MB-1:0] msg;
    logic [1:0]    src;
  } exp_t;

  typedef struct {
    logic                  r;
    logic [NS-1:0]         v;
    logic [NS-1:0][MB-1:0] m;
    logic                  e_val;
    logic [MB-1:0]         e_msg;
    logic [1:0]            e_src;
    logic [NS-1:0]         e_ovf;
  } vec_t;

  logic [MB-1:0] mq    [NS][$];
  logic [MB-1:0] log_q [NS][$];
  exp_t          exp_q [$];
  int            m_ptr;
  logic [NS-1:0] m_ovf;
  logic [MB-1:0] last_msg;
  logic [1:0]    last_src;

  logic          smp_val;
  logic [MB-1:0] smp_msg;
  logic [1:0]    smp_src;
  logic [NS-1:0] smp_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [NS-1:0] v,
                              input logic [NS-1:0][MB-1:0] m, input logic ev,
                              input logic [MB-1:0] em, input logic [1:0] es);
    vec_t t;
    t.r = r; t.v = v; t.m = m;
    t.e_val = ev; t.e_msg = em; t.e_src = es; t.e_ovf = '0;
    return t;
  endfunction

  // Reference model: one arbitration cycle; pushes the expected grant.
  task automatic model_step(input logic r, input logic [NS-1:0] v,
                            input logic [NS-1:0][MB-1:0] m, output bit g);
    int   gs;
    bit   took_arr;
    exp_t e;
    g = 1'b0; gs = 0; took_arr = 1'b0;
    if (!r) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      exp_q.delete();
      m_ptr = 0; m_ovf = '0; last_msg = '0; last_src = '0;
      return;
    end
    for (int k = 0; k < NS; k++) begin
      int s;
      s = (m_ptr + k) % NS;
      if (!g && (mq[s].size() > 0 || v[s])) begin g = 1'b1; gs = s; end
    end
    if (g) begin
      e.src = gs[1:0];
      if (mq[gs].size() > 0) e.msg = mq[gs].pop_front();
      else begin e.msg = m[gs]; took_arr = 1'b1; end
      exp_q.push_back(e);
      m_ptr = (gs + 1) % NS;
    end
    for (int i = 0; i < NS; i++) begin
      if (v[i] && !(g && gs == i && took_arr)) begin
        if (mq[i].size() < DEPTH) mq[i].push_back(m[i]);
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  // Compare the DUT output against the scoreboard for this cycle's grant.
  task automatic sample_out(input bit g);
    exp_t e;
    smp_val = bus.out_val;
    smp_msg = bus.out_msg;
    smp_src = bus.out_src;
    chk("out_val", 64'(smp_val), 64'(g));
    if (g) begin
      e = exp_q.pop_front();
      if (smp_val) begin
        chk("out_msg", 64'(smp_msg), 64'(e.msg));
        chk("out_src", 64'(smp_src), 64'(e.src));
        log_q[smp_src].push_back(smp_msg);
      end
      last_msg = e.msg;
      last_src = e.src;
    end else begin
`ifdef NOTIF_ARBITER_BYPASS_EN
      chk("idle_msg", 64'(smp_msg), 64'(0));
      chk("idle_src", 64'(smp_src), 64'(0));
`else
      chk("idle_msg_hold", 64'(smp_msg), 64'(last_msg));
      chk("idle_src_hold", 64'(smp_src), 64'(last_src));
`endif
    end
  endtask

  task automatic step(input logic r, input logic [NS-1:0] v, input logic [NS-1:0][MB-1:0] m);
    bit g;
    rst = r;
    bus.src_val = v;
    bus.src_msg = m;
    model_step(r, v, m, g);
    #1;
`ifdef NOTIF_ARBITER_BYPASS_EN
    sample_out(g);
`endif
    @(posedge clk);
    #1;
`ifndef NOTIF_ARBITER_BYPASS_EN
    sample_out(g);
`endif
    smp_ovf = bus.overflow;
    chk("overflow", 64'(smp_ovf), 64'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(1'b1, '0, '0);
  endtask

  task automatic clear_logs();
    for (int i = 0; i < NS; i++) log_q[i].delete();
  endtask

  initial begin
    logic [NS-1:0][MB-1:0] mm;

    tbl[0]  = mk(1'b1, 4'b0100, {32'h0, 32'hCAFE0002, 32'h0, 32'h0}, 1'b1, 32'hCAFE0002, 2'd2);
    tbl[1]  = mk(1'b1, 4'b0000, '0,                                  1'b0, 32'h0,        2'd0);
    tbl[2]  = mk(1'b0, 4'b0000, '0,                                  1'b0, 32'h0,        2'd0);
    tbl[3]  = mk(1'b1, 4'b1111, {32'h13, 32'h12, 32'h11, 32'h10},    1'b1, 32'h10,       2'd0);
    tbl[4]  = mk(1'b1, 4'b0000, '0,                                  1'b1, 32'h11,       2'd1);
    tbl[5]  = mk(1'b1, 4'b0000, '0,                                  1'b1, 32'h12,       2'd2);
    tbl[6]  = mk(1'b1, 4'b0000, '0,                                  1'b1, 32'h13,       2'd3);
    tbl[7]  = mk(1'b1, 4'b0000, '0,                                  1'b0, 32'h0,        2'd0);
    tbl[8]  = mk(1'b1, 4'b1010, {32'h23, 32'h0, 32'h21, 32'h0},      1'b1, 32'h21,       2'd1);
    tbl[9]  = mk(1'b1, 4'b0001, {32'h0, 32'h0, 32'h0, 32'h30},       1'b1, 32'h23,       2'd3);
    tbl[10] = mk(1'b1, 4'b0000, '0,                                  1'b1, 32'h30,       2'd0);
    tbl[11] = mk(1'b1, 4'b0000, '0,                                  1'b0, 32'h0,        2'd0);

    bus.src_val = '0;
    bus.src_msg = '0;
    m_ptr = 0; m_ovf = '0; last_msg = '0; last_src = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step(1'b0, '0, '0);
    chk("rst_out_val",  64'(bus.out_val),  64'(0));
    chk("rst_out_msg",  64'(bus.out_msg),  64'(0));
    chk("rst_out_src",  64'(bus.out_src),  64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));

    // Hand-derived cycle vectors
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].m);
      chk($sformatf("tbl%0d_val", i), 64'(smp_val), 64'(tbl[i].e_val));
      if (tbl[i].e_val) begin
        chk($sformatf("tbl%0d_msg", i), 64'(smp_msg), 64'(tbl[i].e_msg));
        chk($sformatf("tbl%0d_src", i), 64'(smp_src), 64'(tbl[i].e_src));
      end
      chk($sformatf("tbl%0d_ovf", i), 64'(smp_ovf), 64'(tbl[i].e_ovf));
    end

    // Source 1 bursts A0..A3 against sources 0 and 2 strobing every cycle;
    // its FIFO saturates and A3 is dropped.
    step(1'b0, '0, '0);
    clear_logs();
    for (int c = 0; c < 4; c++) begin
      mm = '0;
      mm[0] = 32'h100 + c;
      mm[1] = 32'hA0 + c;
      mm[2] = 32'h200 + c;
      step(1'b1, 4'b0111, mm);
    end
    idle(8);
    chk("burst_ovf1", 64'(bus.overflow[1]), 64'(1));
    chk("burst_ovf0", 64'(bus.overflow[0]), 64'(0));
    chk("burst_ovf3", 64'(bus.overflow[3]), 64'(0));
    chk("burst_src1_count", 64'(log_q[1].size()), 64'(3));
    if (log_q[1].size() == 3) begin
      chk("burst_src1_0", 64'(log_q[1][0]), 64'(32'hA0));
      chk("burst_src1_1", 64'(log_q[1][1]), 64'(32'hA1));
      chk("burst_src1_2", 64'(log_q[1][2]), 64'(32'hA2));
    end

    // Source 3 FIFO full, granted while a new arrival comes in: no drop.
    step(1'b0, '0, '0);
    clear_logs();
    step(1'b1, 4'b1011, {32'hD0, 32'h0, 32'hA0, 32'hE0});
    step(1'b1, 4'b1011, {32'hD1, 32'h0, 32'hA1, 32'hE1});
    step(1'b1, 4'b1000, {32'hD2, 32'h0, 32'h0, 32'h0});
`ifndef NOTIF_ARBITER_BYPASS_EN
    chk("fullgnt_src", 64'(smp_src), 64'(3));
`endif
    chk("fullgnt_ovf3", 64'(bus.overflow[3]), 64'(0));
    idle(6);
    chk("fullgnt_ovf_all", 64'(bus.overflow), 64'(0));
    chk("fullgnt_src3_count", 64'(log_q[3].size()), 64'(3));
    if (log_q[3].size() == 3) begin
      chk("fullgnt_src3_0", 64'(log_q[3][0]), 64'(32'hD0));
      chk("fullgnt_src3_1", 64'(log_q[3][1]), 64'(32'hD1));
      chk("fullgnt_src3_2", 64'(log_q[3][2]), 64'(32'hD2));
    end

    // Three pending messages discarded by a one-cycle reset.
    step(1'b0, '0, '0);
    step(1'b1, 4'b1111, {32'h43, 32'h42, 32'h41, 32'h40});
    chk("rstburst_first", 64'(smp_msg), 64'(32'h40));
    step(1'b0, 4'b1111, {32'h53, 32'h52, 32'h51, 32'h50});
    clear_logs();
    idle(6);
    chk("rstburst_emitted",
        64'(log_q[0].size() + log_q[1].size() + log_q[2].size() + log_q[3].size()), 64'(0));
    chk("rstburst_ovf", 64'(bus.overflow), 64'(0));

`ifdef NOTIF_ARBITER_BYPASS_EN
    // Zero-latency path
    step(1'b0, '0, '0);
    rst = 1'b1;
    bus.src_val = 4'b0001;
    bus.src_msg = {32'h0, 32'h0, 32'h0, 32'h55};
    #1;
    chk("byp_val", 64'(bus.out_val), 64'(1));
    chk("byp_msg", 64'(bus.out_msg), 64'(32'h55));
    chk("byp_src", 64'(bus.out_src), 64'(0));
    step(1'b0, '0, '0);
`endif

    // Random traffic with occasional reset, checked by the scoreboard.
    step(1'b0, '0, '0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++) mm[i] = $urandom;
      step(($urandom_range(0, 59) != 0), 4'($urandom_range(0, 15)), mm);
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
